// File: rtl/epu_out_axi_slave_if.sv
// AXI4 read/write channel bundle between the interconnect and the
// EPU output-buffer slave front end.
interface epu_out_axi_slave_if #(
    parameter int ID_W = 8
);
    logic [ID_W-1:0] ARID;
    logic [31:0]     ARADDR;
    logic [3:0]      ARLEN;
    logic            ARVALID;
    logic            ARREADY;

    logic [ID_W-1:0] RID;
    logic [31:0]     RDATA;
    logic [1:0]      RRESP;
    logic            RLAST;
    logic            RVALID;
    logic            RREADY;

    logic [ID_W-1:0] AWID;
    logic [31:0]     AWADDR;
    logic [3:0]      AWLEN;
    logic            AWVALID;
    logic            AWREADY;

    logic [31:0]     WDATA;
    logic            WLAST;
    logic            WVALID;
    logic            WREADY;

    logic [ID_W-1:0] BID;
    logic [1:0]      BRESP;
    logic            BVALID;
    logic            BREADY;

    modport master (
        output ARID, ARADDR, ARLEN, ARVALID,
        input  ARREADY,
        input  RID, RDATA, RRESP, RLAST, RVALID,
        output RREADY,
        output AWID, AWADDR, AWLEN, AWVALID,
        input  AWREADY,
        output WDATA, WLAST, WVALID,
        input  WREADY,
        input  BID, BRESP, BVALID,
        output BREADY
    );

    modport slave (
        input  ARID, ARADDR, ARLEN, ARVALID,
        output ARREADY,
        output RID, RDATA, RRESP, RLAST, RVALID,
        input  RREADY,
        input  AWID, AWADDR, AWLEN, AWVALID,
        output AWREADY,
        input  WDATA, WLAST, WVALID,
        output WREADY,
        output BID, BRESP, BVALID,
        input  BREADY
    );
endinterface

// File: rtl/epu_out_axi_slave.sv
// AXI4 slave front end for the EPU output buffer: converts single-outstanding
// bursts into per-beat strobes, CS/OE, address and write data for the wrapper.
module epu_out_axi_slave #(
    parameter int          ID_W = 8,
    parameter logic [31:0] BASE = 32'h4000_0000
) (
    input  logic        clk,
    input  logic        rst,
    epu_out_axi_slave_if.slave axi,
    output logic        enb_o,
    output logic        cs_o,
    output logic        oe_o,
    output logic [31:0] addr_o,
    output logic [31:0] wdata_o,
    output logic        arhns_o,
    output logic        awhns_o,
    output logic        rhns_o,
    output logic        whns_o,
    output logic        rdfin_o,
    output logic        wrfin_o,
    input  logic        rvalid_i,
    input  logic [31:0] rdata_i
);
    localparam logic [11:0] WIN    = BASE[31:20];
    localparam logic [1:0]  OKAY   = 2'b00;
    localparam logic [1:0]  SLVERR = 2'b10;
    localparam logic [1:0]  DECERR = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RWAIT,
        S_RSEND,
        S_WGAP,
        S_WDATA,
        S_WRESP
    } state_t;

    state_t          state_q, state_d;
    logic            arm_q, arm_d;
    logic [ID_W-1:0] id_q, id_d;
    logic [31:0]     addr_q, addr_d;
    logic [3:0]      len_q, len_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            inwin_q, inwin_d;
    logic            err_q, err_d;
    logic [31:0]     rdata_q, rdata_d;

    logic [31:0] addr_nxt;
    logic        last;

    // Increment stays inside the 1MB window; the window bits never move.
    assign addr_nxt = {addr_q[31:20], addr_q[19:2] + 18'd1, addr_q[1:0]};
    assign last     = (cnt_q == len_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            arm_q   <= 1'b0;
            id_q    <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            inwin_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            arm_q   <= arm_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            inwin_q <= inwin_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        arm_d   = 1'b1;
        id_d    = id_q;
        addr_d  = addr_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        inwin_d = inwin_q;
        err_d   = err_q;
        rdata_d = rdata_q;

        axi.ARREADY = 1'b0;
        axi.AWREADY = 1'b0;
        axi.RVALID  = 1'b0;
        axi.RLAST   = 1'b0;
        axi.RRESP   = OKAY;
        axi.WREADY  = 1'b0;
        axi.BVALID  = 1'b0;
        axi.BRESP   = OKAY;
        cs_o        = 1'b0;
        oe_o        = 1'b0;
        wdata_o     = '0;
        arhns_o     = 1'b0;
        awhns_o     = 1'b0;
        rhns_o      = 1'b0;
        whns_o      = 1'b0;
        rdfin_o     = 1'b0;
        wrfin_o     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                // arm_q keeps both READYs low until the first edge out of reset.
                axi.ARREADY = arm_q;
                axi.AWREADY = arm_q & ~axi.ARVALID;
                if (arm_q && axi.ARVALID) begin
                    arhns_o = 1'b1;
                    id_d    = axi.ARID;
                    addr_d  = axi.ARADDR;
                    len_d   = axi.ARLEN;
                    cnt_d   = '0;
                    inwin_d = (axi.ARADDR[31:20] == WIN);
                    state_d = S_RWAIT;
                end else if (arm_q && axi.AWVALID) begin
                    awhns_o = 1'b1;
                    id_d    = axi.AWID;
                    addr_d  = axi.AWADDR;
                    len_d   = axi.AWLEN;
                    cnt_d   = '0;
                    inwin_d = (axi.AWADDR[31:20] == WIN);
                    err_d   = 1'b0;
                    state_d = S_WGAP;
                end
            end
            S_RWAIT: begin
                cs_o = 1'b1;
                oe_o = 1'b1;
                if (!inwin_q) begin
                    rdata_d = '0;
                    state_d = S_RSEND;
                end else if (rvalid_i) begin
                    rdata_d = rdata_i;
                    state_d = S_RSEND;
                end
            end
            S_RSEND: begin
                axi.RVALID = 1'b1;
                axi.RLAST  = last;
                axi.RRESP  = inwin_q ? OKAY : DECERR;
                if (axi.RREADY) begin
                    if (last) begin
                        rdfin_o = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        rhns_o  = 1'b1;
                        addr_d  = addr_nxt;
                        cnt_d   = cnt_q + 4'd1;
                        state_d = S_RWAIT;
                    end
                end
            end
            S_WGAP: begin
                cs_o    = 1'b1;
                state_d = S_WDATA;
            end
            S_WDATA: begin
                cs_o       = 1'b1;
                axi.WREADY = 1'b1;
                wdata_o    = axi.WDATA;
                if (axi.WVALID) begin
                    whns_o = inwin_q;
                    addr_d = addr_nxt;
                    cnt_d  = cnt_q + 4'd1;
                    if (axi.WLAST != last)
                        err_d = 1'b1;
                    if (last) begin
                        wrfin_o = 1'b1;
                        state_d = S_WRESP;
                    end
                end
            end
            S_WRESP: begin
                axi.BVALID = 1'b1;
                axi.BRESP  = !inwin_q ? DECERR :
                             err_q    ? SLVERR : OKAY;
                if (axi.BREADY)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign axi.RID   = id_q;
    assign axi.BID   = id_q;
    assign axi.RDATA = rdata_q;
    assign addr_o    = addr_q;
    assign enb_o     = inwin_q && (state_q != S_IDLE);
endmodule
